maze_solver: RTL and testbench
==============================

# maze_solver

Downstream consumer of `maze_generator`. It latches a finished maze (`h_walls`/`v_walls`) and walks it from the entrance cell (0,0) to the exit cell (9,14) using the right-hand wall-follower rule. It emits the visited cells one per handshake, and they drive the path overlay and replay logic. It reports completion, step count, or failure.

## Interface
- `MAZE_W`, 10, columns (x).
- `MAZE_H`, 15, rows (y).
- `MAX_STEPS`, 600, move limit before declaring failure; must be < 1024.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse; sampled only when idle (`busy`=0).
- `h_walls` in 160: bit `y*10+x` = wall on top edge of cell (x,y); row 15 = bottom border.
- `v_walls` in 165: bit `y*11+x` = wall on left edge of cell (x,y); column 10 = right border.
- `step_valid` out 1: `step_x`/`step_y` hold a path cell.
- `step_ready` in 1: consumer accepts the cell on `step_valid & step_ready`.
- `step_x` out 4: cell column.
- `step_y` out 4: cell row.
- `step_count` out 10: moves completed since `start`.
- `busy` out 1: solve in progress.
- `done` out 1: exit reached; held until next `start`/`rst`.
- `fail` out 1: enclosed cell or `MAX_STEPS` exceeded; held until next `start`/`rst`.

## Operation
- States: IDLE, EMIT, DONE, FAIL. DONE and FAIL behave as IDLE for `start`.
- Reset: state IDLE; all outputs 0; heading S; position (0,0).
- `start` in IDLE/DONE/FAIL:
  - Copy both wall vectors into internal registers; later input changes are ignored.
  - Position (0,0), heading S, `step_count`=0, `done`/`fail` cleared, then EMIT.
- `start` while in EMIT is ignored.
- EMIT: `step_valid`=1 presenting the current cell; outputs are stable until the handshake.
- Open mask is combinational from the registered walls:
  - N open = !top(x,y) && y>0.
  - S open = !top(x,y+1) && y<14.
  - W open = !left(x,y) && x>0.
  - E open = !left(x+1,y) && x<9.
  - Border cells are always walls, whatever the border bit values.
- Direction priority relative to heading: right, straight, left, back. First open direction wins.
- On handshake:
  - Current cell == (9,14): go to DONE, `done`=1.
  - Else mask all-zero: go to FAIL.
  - Else `step_count`==MAX_STEPS: go to FAIL.
  - Else move one cell, set heading to chosen direction, `step_count`+1, stay in EMIT.
- Heading encoding: 0=N(y-1), 1=E(x+1), 2=S(y+1), 3=W(x-1). Right = heading+1 mod 4, left = heading+3 mod 4, back = heading+2 mod 4.

## Timing
- `start` sampled at edge T → `busy`=1 and `step_valid`=1 with (0,0) from T+1.
- Throughput: one cell per cycle while `step_ready`=1. The next cell appears the cycle after each handshake; `step_valid` stays high.
- Final handshake at edge E → `step_valid`=0, `busy`=0, and `done` or `fail`=1 from E+1.
- `rst` overrides everything, including mid-solve and simultaneous `start`. Outputs return to reset values the cycle after.

## Structure
- Package `maze_pkg` holds:
  - `MAZE_W`/`MAZE_H`, wall vector widths (160/165).
  - Direction constants and turn helpers.
  - Index functions `top_idx(x,y)` and `left_idx(x,y)`, shared with `maze_generator`.
- Sub-module `maze_cell_walls`: combinational. Takes registered walls plus (x,y) and returns a 4-bit open mask {W,S,E,N} with border forcing.

## Test plan
- Open maze (all interior walls 0, borders 1), `step_ready`=1:
  - Cells are (0,0)…(0,14), then (1,14)…(9,14), 24 cells in total.
  - `done`=1, `step_count`=23.
- Same maze with all border bits 0 → identical 24-cell sequence (border forcing).
- All walls 1 → (0,0) emitted once, then `fail`=1, `done`=0, `step_count`=0.
- Open maze, MAX_STEPS=10:
  - Last cell emitted is (0,10), then `fail`=1, `step_count`=10.
- Backpressure: drop `step_ready` for 5 cycles at cell (0,3).
  - `step_valid`=1 and (0,3) are stable throughout.
  - Sequence and final count are unchanged.
- `start` pulse at step 4 is ignored.
- `rst` at step 6 → all outputs 0 next cycle.
- New `start` after reset reproduces the identical sequence from (0,0).

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze geometry, direction encoding and wall-vector index helpers.
package maze_pkg;

    localparam int unsigned MAZE_W     = 10;
    localparam int unsigned MAZE_H     = 15;
    localparam int unsigned HWALL_BITS = MAZE_W * (MAZE_H + 1);  // 160, includes bottom border row
    localparam int unsigned VWALL_BITS = (MAZE_W + 1) * MAZE_H;  // 165, includes right border column
    localparam int unsigned COORD_W    = 4;
    localparam int unsigned IDX_W      = 8;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [IDX_W-1:0]   widx_t;

    localparam coord_t LAST_X = coord_t'(MAZE_W - 1);
    localparam coord_t LAST_Y = coord_t'(MAZE_H - 1);

    // Heading doubles as the bit position in the {W,S,E,N} open mask.
    typedef logic [1:0] dir_t;
    localparam dir_t DIR_N = 2'd0;
    localparam dir_t DIR_E = 2'd1;
    localparam dir_t DIR_S = 2'd2;
    localparam dir_t DIR_W = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StDone,
        StFail
    } state_e;

    function automatic dir_t turn_right(input dir_t d);
        return d + 2'd1;
    endfunction

    function automatic dir_t turn_left(input dir_t d);
        return d + 2'd3;
    endfunction

    function automatic dir_t turn_back(input dir_t d);
        return d + 2'd2;
    endfunction

    // Bit of h_walls holding the top edge of cell (x,y).
    function automatic widx_t top_idx(input coord_t x, input coord_t y);
        return widx_t'(y) * widx_t'(MAZE_W) + widx_t'(x);
    endfunction

    // Bit of v_walls holding the left edge of cell (x,y).
    function automatic widx_t left_idx(input coord_t x, input coord_t y);
        return widx_t'(y) * widx_t'(MAZE_W + 1) + widx_t'(x);
    endfunction

endpackage

// File: rtl/maze_cell_walls.sv
// Combinational open-direction mask for one cell; border edges are always closed.
module maze_cell_walls
    import maze_pkg::*;
(
    input  logic [HWALL_BITS-1:0] h_walls_i,
    input  logic [VWALL_BITS-1:0] v_walls_i,
    input  logic [COORD_W-1:0]    x_i,
    input  logic [COORD_W-1:0]    y_i,
    output logic [3:0]            open_o
);

    // Look up the four edges of (x,y) and force the maze perimeter closed.
    always_comb begin
        open_o        = '0;
        open_o[DIR_N] = !h_walls_i[top_idx(x_i, y_i)] && (y_i != '0);
        open_o[DIR_S] = !h_walls_i[top_idx(x_i, y_i + 4'd1)] && (y_i != LAST_Y);
        open_o[DIR_W] = !v_walls_i[left_idx(x_i, y_i)] && (x_i != '0);
        open_o[DIR_E] = !v_walls_i[left_idx(x_i + 4'd1, y_i)] && (x_i != LAST_X);
    end

endmodule

// File: rtl/maze_solver.sv
// Right-hand wall follower: walks a latched maze from (0,0) to the exit,
// emitting each visited cell over a valid/ready handshake.
module maze_solver
    import maze_pkg::*;
#(
    parameter int unsigned MAX_STEPS = 600  // must stay below 1024 to fit step_count
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [HWALL_BITS-1:0] h_walls,
    input  logic [VWALL_BITS-1:0] v_walls,
    output logic                  step_valid,
    input  logic                  step_ready,
    output logic [COORD_W-1:0]    step_x,
    output logic [COORD_W-1:0]    step_y,
    output logic [9:0]            step_count,
    output logic                  busy,
    output logic                  done,
    output logic                  fail
);

    state_e                state_q, state_d;
    logic [HWALL_BITS-1:0] hw_q, hw_d;
    logic [VWALL_BITS-1:0] vw_q, vw_d;
    coord_t                x_q, x_d;
    coord_t                y_q, y_d;
    dir_t                  head_q, head_d;
    logic [9:0]            count_q, count_d;

    logic [3:0] open_mask;
    dir_t       dir_sel;
    coord_t     x_step, y_step;
    logic       at_exit;

    maze_cell_walls u_cell_walls (
        .h_walls_i (hw_q),
        .v_walls_i (vw_q),
        .x_i       (x_q),
        .y_i       (y_q),
        .open_o    (open_mask)
    );

    assign at_exit = (x_q == LAST_X) && (y_q == LAST_Y);

    // Pick the first open direction in right/straight/left/back order.
    always_comb begin
        if (open_mask[turn_right(head_q)]) begin
            dir_sel = turn_right(head_q);
        end else if (open_mask[head_q]) begin
            dir_sel = head_q;
        end else if (open_mask[turn_left(head_q)]) begin
            dir_sel = turn_left(head_q);
        end else begin
            dir_sel = turn_back(head_q);
        end
    end

    // Neighbour cell in the chosen direction.
    always_comb begin
        x_step = x_q;
        y_step = y_q;
        unique case (dir_sel)
            DIR_N:   y_step = y_q - 4'd1;
            DIR_E:   x_step = x_q + 4'd1;
            DIR_S:   y_step = y_q + 4'd1;
            default: x_step = x_q - 4'd1;
        endcase
    end

    // Next-state logic: latch on start, advance one cell per handshake.
    always_comb begin
        state_d = state_q;
        hw_d    = hw_q;
        vw_d    = vw_q;
        x_d     = x_q;
        y_d     = y_q;
        head_d  = head_q;
        count_d = count_q;
        unique case (state_q)
            StEmit: begin
                if (step_ready) begin
                    if (at_exit) begin
                        state_d = StDone;
                    end else if (open_mask == 4'b0000) begin
                        state_d = StFail;
                    end else if (count_q == 10'(MAX_STEPS)) begin
                        state_d = StFail;
                    end else begin
                        x_d     = x_step;
                        y_d     = y_step;
                        head_d  = dir_sel;
                        count_d = count_q + 10'd1;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d = StEmit;
                    hw_d    = h_walls;
                    vw_d    = v_walls;
                    x_d     = '0;
                    y_d     = '0;
                    head_d  = DIR_S;
                    count_d = '0;
                end
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            hw_q    <= '0;
            vw_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            head_q  <= DIR_S;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hw_q    <= hw_d;
            vw_q    <= vw_d;
            x_q     <= x_d;
            y_q     <= y_d;
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    assign step_valid = (state_q == StEmit);
    assign busy       = (state_q == StEmit);
    assign done       = (state_q == StDone);
    assign fail       = (state_q == StFail);
    assign step_x     = x_q;
    assign step_y     = y_q;
    assign step_count = count_q;

endmodule

// File: tb/tb_maze_solver.sv
// Scoreboard bench: two solvers (MAX_STEPS 600 and 10) share stimulus; a
// behavioural wall-follower model fills per-instance expectation queues.
module tb_maze_solver;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         step_ready = 1'b0;
    logic [159:0] h_walls = '0;
    logic [164:0] v_walls = '0;

    logic       v0, v1, b0, b1, d0, d1, f0, f1;
    logic [3:0] x0, y0, x1, y1;
    logic [9:0] c0, c1;

    maze_solver #(.MAX_STEPS(600)) dut0 (
        .clk(clk), .rst(rst), .start(start), .h_walls(h_walls), .v_walls(v_walls),
        .step_valid(v0), .step_ready(step_ready), .step_x(x0), .step_y(y0),
        .step_count(c0), .busy(b0), .done(d0), .fail(f0)
    );

    maze_solver #(.MAX_STEPS(10)) dut1 (
        .clk(clk), .rst(rst), .start(start), .h_walls(h_walls), .v_walls(v_walls),
        .step_valid(v1), .step_ready(step_ready), .step_x(x1), .step_y(y1),
        .step_count(c1), .busy(b1), .done(d1), .fail(f1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int q0[$];  // expected cells, encoded x*16+y
    int q1[$];
    int e0[$];  // expected end state, encoded done<<11 | fail<<10 | count
    int e1[$];
    bit end_req = 1'b0;

    // ---------------- reference model ----------------
    function automatic bit wbit(input logic [164:0] vec, input int idx);
        logic [164:0] t;
        t = vec >> idx;
        return t[0];
    endfunction

    function automatic bit is_open(input logic [159:0] h, input logic [164:0] v,
                                   input int x, input int y, input int d);
        case (d)
            0:       return (y > 0)  && !wbit({5'b0, h}, y * 10 + x);
            1:       return (x < 9)  && !wbit(v, y * 11 + x + 1);
            2:       return (y < 14) && !wbit({5'b0, h}, (y + 1) * 10 + x);
            default: return (x > 0)  && !wbit(v, y * 11 + x);
        endcase
    endfunction

    task automatic run_model(input logic [159:0] h, input logic [164:0] v,
                             input int max_steps, input int which);
        int x, y, hd, cnt, found, d;
        bit dn, fl;
        int order[4] = '{1, 0, 3, 2};
        int dx[4]    = '{0, 1, 0, -1};
        int dy[4]    = '{-1, 0, 1, 0};
        x = 0; y = 0; hd = 2; cnt = 0; dn = 0; fl = 0;
        while (1) begin
            if (which == 0) q0.push_back(x * 16 + y);
            else            q1.push_back(x * 16 + y);
            if (x == 9 && y == 14) begin dn = 1; break; end
            found = -1;
            for (int k = 0; k < 4; k++) begin
                d = (hd + order[k]) % 4;
                if (found < 0 && is_open(h, v, x, y, d)) found = d;
            end
            if (found < 0 || cnt == max_steps) begin fl = 1; break; end
            x  = x + dx[found];
            y  = y + dy[found];
            hd = found;
            cnt++;
        end
        if (which == 0) e0.push_back((int'(dn) << 11) | (int'(fl) << 10) | cnt);
        else            e1.push_back((int'(dn) << 11) | (int'(fl) << 10) | cnt);
    endtask

    // ---------------- monitor ----------------
    function automatic void chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void flag_fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got unexpected event, required none at %0t", nm, $time);
    endfunction

    bit rst_prev = 1'b0;
    bit end_done = 1'b0;
    bit stall[2];
    int hxy[2];
    bit pb[2];
    int bc[2];

    task automatic mon(input int w, input logic v, input logic b, input logic d,
                       input logic f, input logic [3:0] x, input logic [3:0] y,
                       input logic [9:0] c);
        int exp;
        bit empty;
        if (stall[w]) chk($sformatf("hold%0d", w), int'({v, x, y}), 256 + hxy[w]);
        if (v === 1'b1 && step_ready === 1'b1) begin
            empty = (w == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) flag_fail($sformatf("extra_cell%0d", w));
            else begin
                if (w == 0) exp = q0.pop_front();
                else        exp = q1.pop_front();
                chk($sformatf("cell%0d", w), int'({x, y}), exp);
            end
        end
        stall[w] = (v === 1'b1) && (step_ready !== 1'b1);
        hxy[w]   = int'({x, y});
        if (pb[w] && b === 1'b0) begin
            empty = (w == 0) ? (e0.size() == 0) : (e1.size() == 0);
            if (empty) flag_fail($sformatf("extra_end%0d", w));
            else begin
                if (w == 0) exp = e0.pop_front();
                else        exp = e1.pop_front();
                chk($sformatf("end%0d", w), int'({d, f, c}), exp);
            end
        end
        pb[w] = (b === 1'b1);
        if (b === 1'b1) bc[w]++;
        else            bc[w] = 0;
        if (bc[w] == 3000) flag_fail($sformatf("timeout%0d", w));
    endtask

    always @(negedge clk) begin
        if (rst_prev) begin
            chk("rst_out0", int'({v0, b0, d0, f0, x0, y0, c0}), 0);
            chk("rst_out1", int'({v1, b1, d1, f1, x1, y1, c1}), 0);
            q0.delete(); q1.delete(); e0.delete(); e1.delete();
            for (int w = 0; w < 2; w++) begin
                stall[w] = 0; pb[w] = 0; bc[w] = 0;
            end
        end else begin
            mon(0, v0, b0, d0, f0, x0, y0, c0);
            mon(1, v1, b1, d1, f1, x1, y1, c1);
        end
        if (end_req && !end_done) begin
            chk("left_cells0", q0.size(), 0);
            chk("left_cells1", q1.size(), 0);
            chk("left_ends0", e0.size(), 0);
            chk("left_ends1", e1.size(), 0);
            end_done = 1'b1;
        end
        rst_prev = (rst === 1'b1);
    end

    // ---------------- stimulus ----------------
    // mode 0: random ready; 1: ready high; 2: stall 5 cycles at cell 3;
    // 3: ignored start at step 4; 4: reset at step 6.
    task automatic do_run(input logic [159:0] h, input logic [164:0] v, input int mode);
        int guard;
        run_model(h, v, 600, 0);
        run_model(h, v, 10, 1);
        h_walls    = h;
        v_walls    = v;
        step_ready = 1'b1;
        start      = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        h_walls = {5{$urandom()}};
        v_walls = 165'({6{$urandom()}});
        case (mode)
            2: begin
                repeat (3) @(posedge clk);
                #1 step_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 step_ready = 1'b1;
            end
            3: begin
                repeat (4) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
            4: begin
                repeat (6) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                @(posedge clk); #1;
            end
            default: ;
        endcase
        guard = 0;
        while ((b0 === 1'b1 || b1 === 1'b1) && guard < 4000) begin
            if (mode == 0) step_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            guard++;
        end
        step_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [159:0] ho, hr;
        logic [164:0] vo, vr;
        ho = '0;
        vo = '0;
        for (int x = 0; x < 10; x++) begin
            ho |= 160'(1) << x;
            ho |= 160'(1) << (150 + x);
        end
        for (int y = 0; y < 15; y++) begin
            vo |= 165'(1) << (y * 11);
            vo |= 165'(1) << (y * 11 + 10);
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;

        do_run(ho, vo, 1);        // open maze
        do_run('0, '0, 1);        // border bits cleared
        do_run('1, '1, 1);        // fully enclosed start
        do_run(ho, vo, 2);        // backpressure
        do_run(ho, vo, 3);        // start while busy
        do_run(ho, vo, 4);        // reset mid-solve
        do_run(ho, vo, 1);        // identical rerun after reset
        for (int r = 0; r < 10; r++) begin
            hr = '0;
            vr = '0;
            for (int i = 0; i < 160; i++) if ($urandom_range(0, 4) == 0) hr |= 160'(1) << i;
            for (int i = 0; i < 165; i++) if ($urandom_range(0, 4) == 0) vr |= 165'(1) << i;
            do_run(hr, vr, 0);
        end

        end_req = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
